// File: rtl/axi_mem_pkg.sv
`default_nettype none
// ============================================================================
// axi_mem_pkg : burst/response/state types and the beat address helper
// Revision    : 1.0
// ============================================================================
package axi_mem_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_BURST = 2'd1,
      ST_WR_DATA  = 2'd2,
      ST_WR_RESP  = 2'd3
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Response codes are ordered so that the numerically larger one is worse.
   function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                  input logic [7:0]  len,
                                                  input logic [2:0]  size,
                                                  input burst_e      burst);
      logic [63:0] step;
      logic [63:0] mask;
      logic [63:0] result;
      step = 64'd1 << size;
      mask = ((64'(len) + 64'd1) << size) - 64'd1;
      case (burst)
         BURST_FIXED: result = addr;
         BURST_WRAP:  result = (addr & ~mask) | ((addr + step) & mask);
         default:     result = addr + step;
      endcase
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_bank.sv
`default_nettype none
// ============================================================================
// axi_mem_bank : DEPTH_WORDS x WORD_W storage, byte-strobe write, async read,
//                word i holds i at time zero
// Revision     : 1.0
// ============================================================================
module axi_mem_bank #(
   parameter int DEPTH_WORDS = 4096,
   parameter int WORD_W      = 32,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [IDX_W-1:0]    widx_i,
   input  logic [WORD_W-1:0]   wdata_i,
   input  logic [WORD_W/8-1:0] wstrb_i,
   input  logic [IDX_W-1:0]    ridx_i,
   output logic [WORD_W-1:0]   rdata_o
);

   logic [WORD_W-1:0] w_words [DEPTH_WORDS];

   for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
      logic [WORD_W-1:0] word_q = WORD_W'(i);

      always_ff @(posedge clk_i) begin
         if (we_i && (widx_i == IDX_W'(i))) begin
            for (int b = 0; b < WORD_W / 8; b++) begin
               if (wstrb_i[b]) word_q[8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end

      assign w_words[i] = word_q;
   end

   assign rdata_o = w_words[ridx_i];

endmodule
`default_nettype wire

// File: rtl/axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// axi_burst_mem_slave : single-outstanding AXI4 burst RAM responder
//                       (optional random stalls: AXI_MEM_RAND_STALL_EN)
// Revision            : 1.0
// ============================================================================
module axi_burst_mem_slave
   import axi_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ID_WIDTH    = 4,
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                    s_aclk,
   input  logic                    s_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [1:0]              s_axi_arburst,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [1:0]              s_axi_awburst,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [2:0]              size_q, size_d;
   burst_e                  burst_q, burst_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]     rid_q, rid_d;
   logic [ID_WIDTH-1:0]     bid_q, bid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic                    rlast_q, rlast_d;
   logic                    rvalid_q, rvalid_d;
   logic [1:0]              bresp_q, bresp_d;
   logic                    bvalid_q, bvalid_d;

   logic                    w_stall;
   logic                    w_arready, w_awready, w_wready;
   logic                    w_we;
   logic [ADDR_WIDTH-3:0]   w_word;
   logic                    w_word_oob;
   logic [1:0]              w_beat_resp;
   logic [DATA_WIDTH-1:0]   w_bank_rdata;

`ifdef AXI_MEM_RAND_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) lfsr_q <= 16'hACE1;
      else            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign w_stall = lfsr_q[0];
`else
   assign w_stall = 1'b0;
`endif

   assign w_word      = addr_q[ADDR_WIDTH-1:2];
   assign w_word_oob  = ADDR_WIDTH'(w_word) >= ADDR_WIDTH'(DEPTH_WORDS);
   assign w_beat_resp = w_word_oob ? RESP_DECERR :
                        ((size_q > 3'd2) || (burst_q == BURST_RSVD)) ? RESP_SLVERR : RESP_OKAY;

   axi_mem_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .WORD_W      (DATA_WIDTH),
      .IDX_W       (IDX_W)
   ) u_bank (
      .clk_i   (s_aclk),
      .we_i    (w_we),
      .widx_i  (w_word[IDX_W-1:0]),
      .wdata_i (s_axi_wdata),
      .wstrb_i (s_axi_wstrb),
      .ridx_i  (w_word[IDX_W-1:0]),
      .rdata_o (w_bank_rdata)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      cnt_d     = cnt_q;
      rid_d     = rid_q;
      bid_d     = bid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      rvalid_d  = rvalid_q;
      bresp_d   = bresp_q;
      bvalid_d  = bvalid_q;
      w_arready = 1'b0;
      w_awready = 1'b0;
      w_wready  = 1'b0;
      w_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Writes win when both address channels are valid.
            w_awready = ~w_stall;
            w_arready = ~w_stall & ~s_axi_awvalid;
            if (s_axi_awvalid && w_awready) begin
               addr_d  = s_axi_awaddr;
               len_d   = s_axi_awlen;
               size_d  = s_axi_awsize;
               burst_d = burst_e'(s_axi_awburst);
               bid_d   = s_axi_awid;
               cnt_d   = 8'd0;
               bresp_d = ((s_axi_awsize > 3'd2) || (s_axi_awburst == 2'b11)) ? RESP_SLVERR : RESP_OKAY;
               state_d = ST_WR_DATA;
            end else if (s_axi_arvalid && w_arready) begin
               addr_d  = s_axi_araddr;
               len_d   = s_axi_arlen;
               size_d  = s_axi_arsize;
               burst_d = burst_e'(s_axi_arburst);
               rid_d   = s_axi_arid;
               cnt_d   = 8'd0;
               rlast_d = 1'b0;
               state_d = ST_RD_BURST;
            end
         end

         ST_RD_BURST: begin
            if (rvalid_q && s_axi_rready) begin
               rvalid_d = 1'b0;
               if (rlast_q) begin
                  rlast_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end
            // Refill the R register when it is empty or being drained, until the last beat is loaded.
            if (!(rvalid_q && rlast_q) && (!rvalid_q || s_axi_rready) && (rvalid_q || !w_stall)) begin
               rvalid_d = 1'b1;
               rdata_d  = w_word_oob ? '0 : w_bank_rdata;
               rresp_d  = w_beat_resp;
               rlast_d  = (cnt_q == len_q);
               addr_d   = ADDR_WIDTH'(next_beat_addr(64'(addr_q), len_q, size_q, burst_q));
               cnt_d    = cnt_q + 8'd1;
            end
         end

         ST_WR_DATA: begin
            w_wready = ~w_stall;
            if (s_axi_wvalid && w_wready) begin
               w_we    = ~w_word_oob;
               bresp_d = worst_resp(bresp_q, w_beat_resp);
               if (s_axi_wlast != (cnt_q == len_q)) bresp_d = worst_resp(bresp_d, RESP_SLVERR);
               addr_d  = ADDR_WIDTH'(next_beat_addr(64'(addr_q), len_q, size_q, burst_q));
               cnt_d   = cnt_q + 8'd1;
               if (cnt_q == len_q) begin
                  bvalid_d = 1'b1;
                  state_d  = ST_WR_RESP;
               end
            end
         end

         ST_WR_RESP: begin
            if (bvalid_q && s_axi_bready) begin
               bvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= BURST_FIXED;
         cnt_q    <= '0;
         rid_q    <= '0;
         bid_q    <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         rlast_q  <= 1'b0;
         rvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         bvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         size_q   <= size_d;
         burst_q  <= burst_d;
         cnt_q    <= cnt_d;
         rid_q    <= rid_d;
         bid_q    <= bid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         rlast_q  <= rlast_d;
         rvalid_q <= rvalid_d;
         bresp_q  <= bresp_d;
         bvalid_q <= bvalid_d;
      end
   end

   // Readies are combinational from state, so mask them while reset is held.
   assign s_axi_arready = w_arready & s_aresetn;
   assign s_axi_awready = w_awready & s_aresetn;
   assign s_axi_wready  = w_wready & s_aresetn;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rid     = rid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_bid     = bid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_bvalid  = bvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// tb_axi_burst_mem_slave : randomized bench with a word-array memory model
// Revision               : 1.0
// ============================================================================
module tb_axi_burst_mem_slave;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic [3:0]  arid, awid, rid, bid, wstrb;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int compared = 0;
   int mismatched = 0;
   logic [31:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   axi_burst_mem_slave dut (
      .s_aclk(clk), .s_aresetn(rst_n),
      .s_axi_araddr(araddr), .s_axi_arburst(arburst), .s_axi_arid(arid), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .s_axi_awaddr(awaddr), .s_axi_awburst(awburst), .s_axi_awid(awid), .s_axi_awlen(awlen),
      .s_axi_awsize(awsize), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
      .s_axi_bready(bready)
   );

   // Byte address of beat i, straight from the burst rules.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input int size, input int burst, input int i);
      longint s, step, win, base;
      s    = longint'(start);
      step = longint'(1) << size;
      if (burst == 0) return start;
      if (burst == 2) begin
         win  = longint'(len + 1) * step;
         base = s - (s % win);
         return 32'(base + ((s - base) + longint'(i) * step) % win);
      end
      return 32'(s + longint'(i) * step);
   endfunction

   function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic read_burst(input logic [31:0] addr, input int len, input int size, input int burst,
                             input logic [3:0] id, input int stall_beat, input bit rand_ready,
                             input bit check_lat);
      logic [31:0] a, ed, hd;
      logic [1:0]  er;
      logic        el, hl;
      int          beat, guard;
      bit          stalled;
      @(negedge clk);
      araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arid = id; arvalid = 1'b1;
      #1;
      guard = 0;
      while (arready !== 1'b1 && guard < 100) begin @(negedge clk); #1; guard++; end
      if (arready !== 1'b1) begin
         compared++; mismatched++; arvalid = 1'b0;
         $display("FAIL ar_timeout: arready got %b expected 1", arready);
         return;
      end
      @(negedge clk);
      arvalid = 1'b0;
      if (check_lat) begin
         compared++;
         if (rvalid !== 1'b0) begin mismatched++; $display("FAIL r_latency: rvalid got %b expected 0", rvalid); end
      end
      @(negedge clk);
      beat = 0; guard = 0; stalled = 0;
      while (beat <= len && guard < 3000) begin
         guard++;
         if (rvalid === 1'b1 && beat == stall_beat && !stalled) begin
            hd = rdata; hl = rlast; rready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               compared++;
               if (rvalid !== 1'b1 || rdata !== hd || rlast !== hl) begin
                  mismatched++;
                  $display("FAIL r_stall_hold: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                           rvalid, rdata, rlast, hd, hl);
               end
            end
            stalled = 1;
         end
         rready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (check_lat) begin
            compared++;
            if (rvalid !== 1'b1) begin mismatched++; $display("FAIL r_gap beat %0d: rvalid got %b expected 1", beat, rvalid); end
         end
         if (rvalid === 1'b1 && rready) begin
            a = beat_addr(addr, len, size, burst, beat);
            if ((a >> 2) >= DEPTH) begin ed = 32'h0; er = 2'b11; end
            else begin
               ed = mem_m[int'(a >> 2)];
               er = (size > 2 || burst == 3) ? 2'b10 : 2'b00;
            end
            el = (beat == len);
            compared++;
            if (rdata !== ed || rresp !== er || rlast !== el || rid !== id) begin
               mismatched++;
               $display("FAIL r_beat %0d @%h: got data=%h resp=%0d last=%b id=%h expected data=%h resp=%0d last=%b id=%h",
                        beat, a, rdata, rresp, rlast, rid, ed, er, el, id);
            end
            beat++;
         end
         @(negedge clk);
      end
      rready = 1'b0;
      compared++;
      if (beat <= len || rvalid !== 1'b0) begin
         mismatched++;
         $display("FAIL r_end: got beats=%0d rvalid=%b expected beats=%0d rvalid=0", beat, rvalid, len + 1);
      end
      if (check_lat) begin
         compared++;
         if (arready !== 1'b1) begin mismatched++; $display("FAIL r_idle: arready got %b expected 1", arready); end
      end
   endtask

   task automatic write_burst(input logic [31:0] addr, input int len, input int size, input int burst,
                              input logic [3:0] id, input int bad_last, input bit gaps,
                              input bit fixed, input logic [31:0] d0, input logic [3:0] s0);
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [1:0]  exp_b;
      logic        lastv;
      int          guard;
      @(negedge clk);
      awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awid = id; awvalid = 1'b1;
      #1;
      guard = 0;
      while (awready !== 1'b1 && guard < 100) begin @(negedge clk); #1; guard++; end
      if (awready !== 1'b1) begin
         compared++; mismatched++; awvalid = 1'b0;
         $display("FAIL aw_timeout: awready got %b expected 1", awready);
         return;
      end
      @(negedge clk);
      awvalid = 1'b0;
      exp_b = (size > 2 || burst == 3) ? 2'b10 : 2'b00;
      for (int b = 0; b <= len; b++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         d = fixed ? d0 : $urandom;
         s = fixed ? s0 : 4'($urandom_range(0, 15));
         lastv = (b == len) ^ (b == bad_last);
         wdata = d; wstrb = s; wlast = lastv; wvalid = 1'b1;
         #1;
         guard = 0;
         while (wready !== 1'b1 && guard < 100) begin @(negedge clk); #1; guard++; end
         if (wready !== 1'b1) begin
            compared++; mismatched++; wvalid = 1'b0;
            $display("FAIL w_timeout: wready got %b expected 1", wready);
            return;
         end
         a = beat_addr(addr, len, size, burst, b);
         if ((a >> 2) >= DEPTH) exp_b = worst(exp_b, 2'b11);
         else begin
            for (int k = 0; k < 4; k++)
               if (s[k]) mem_m[int'(a >> 2)][8*k +: 8] = d[8*k +: 8];
         end
         if (lastv != (b == len)) exp_b = worst(exp_b, 2'b10);
         @(negedge clk);
         wvalid = 1'b0; wlast = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      guard = 0;
      while (bvalid !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      compared++;
      if (bvalid !== 1'b1 || bresp !== exp_b || bid !== id) begin
         mismatched++;
         $display("FAIL b_resp: got valid=%b resp=%0d id=%h expected valid=1 resp=%0d id=%h",
                  bvalid, bresp, bid, exp_b, id);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      compared++;
      if (bvalid !== 1'b0) begin mismatched++; $display("FAIL b_drop: bvalid got %b expected 0", bvalid); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0; wlast = 0;
      araddr = 0; awaddr = 0; wdata = 0; wstrb = 0; arburst = 0; awburst = 0;
      arid = 0; awid = 0; arlen = 0; awlen = 0; arsize = 0; awsize = 0;
      #1;
      compared++;
      if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
         mismatched++;
         $display("FAIL reset_handshake: got ar/aw/w/rv/bv/rlast=%b expected 000000",
                  {arready, awready, wready, rvalid, bvalid, rlast});
      end
      compared++;
      if (rdata !== 32'h0 || rresp !== 2'b0 || bresp !== 2'b0 || rid !== 4'h0 || bid !== 4'h0) begin
         mismatched++;
         $display("FAIL reset_data: got rdata=%h rresp=%0d bresp=%0d rid=%h bid=%h expected all 0",
                  rdata, rresp, bresp, rid, bid);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_ready: got ar=%b aw=%b w=%b expected 1 1 0", arready, awready, wready);
      end
   endtask

   task automatic test_incr_read();
      read_burst(32'h40, 3, 2, 1, 4'h7, -1, 0, 1);
   endtask

   task automatic test_single_write();
      write_burst(32'h8, 0, 2, 1, 4'h2, -1, 0, 1, 32'hDEADBEEF, 4'b0011);
      read_burst(32'h8, 0, 2, 1, 4'h1, -1, 0, 1);
   endtask

   task automatic test_wrap_read();
      read_burst(32'h48, 3, 2, 2, 4'hA, -1, 0, 1);
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      d = $urandom;
      @(negedge clk);
      araddr = 32'h0; arlen = 0; arsize = 2; arburst = 1; arid = 4'h3; arvalid = 1'b1;
      awaddr = 32'h4; awlen = 0; awsize = 2; awburst = 1; awid = 4'h5; awvalid = 1'b1;
      #1;
      compared++;
      if (awready !== 1'b1 || arready !== 1'b0) begin
         mismatched++; $display("FAIL sim_priority: got aw=%b ar=%b expected aw=1 ar=0", awready, arready);
      end
      @(negedge clk);
      awvalid = 1'b0; wdata = d; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      #1;
      compared++;
      if (arready !== 1'b0 || wready !== 1'b1) begin
         mismatched++; $display("FAIL sim_wphase: got ar=%b w=%b expected ar=0 w=1", arready, wready);
      end
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
      mem_m[1] = d;
      compared++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || bid !== 4'h5 || arready !== 1'b0) begin
         mismatched++;
         $display("FAIL sim_b: got bvalid=%b bresp=%0d bid=%h ar=%b expected 1 0 5 0", bvalid, bresp, bid, arready);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      #1;
      compared++;
      if (arready !== 1'b1) begin mismatched++; $display("FAIL sim_ar_after_b: arready got %b expected 1", arready); end
      @(negedge clk);
      arvalid = 1'b0;
      @(negedge clk);
      compared++;
      if (rvalid !== 1'b1 || rdata !== mem_m[0] || rid !== 4'h3 || rlast !== 1'b1) begin
         mismatched++;
         $display("FAIL sim_read0: got valid=%b data=%h id=%h last=%b expected 1 %h 3 1", rvalid, rdata, rid, rlast, mem_m[0]);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      read_burst(32'h4, 0, 2, 1, 4'h6, -1, 0, 1);
   endtask

   task automatic test_rready_stall();
      read_burst(32'h200 + 32'($urandom_range(0, 63)) * 4, 7, 2, 1, 4'h9, 1, 0, 0);
   endtask

   task automatic test_decerr();
      read_burst(32'(DEPTH * 4), 0, 2, 1, 4'h4, -1, 0, 1);
      read_burst(32'(DEPTH * 4 - 8), 3, 2, 1, 4'h4, -1, 0, 1);
      write_burst(32'(DEPTH * 4), 0, 2, 1, 4'hB, -1, 0, 1, 32'hA5A5A5A5, 4'hF);
      read_burst(32'h0, 1, 2, 1, 4'h4, -1, 0, 1);
   endtask

   task automatic test_slverr();
      read_burst(32'h100, 3, 2, 3, 4'hC, -1, 0, 1);
      read_burst(32'h100, 1, 3, 1, 4'hC, -1, 0, 1);
      write_burst(32'h300, 2, 2, 1, 4'hD, 0, 0, 0, 32'h0, 4'h0);
      write_burst(32'h310, 1, 2, 1, 4'hD, 1, 1, 0, 32'h0, 4'h0);
      read_burst(32'h300, 5, 2, 1, 4'hD, -1, 1, 0);
   endtask

   task automatic test_random();
      int          burst, size, len, bad;
      logic [31:0] addr;
      for (int t = 0; t < 60; t++) begin
         burst = $urandom_range(0, 3);
         size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         len   = (burst == 2) ? ((2 << $urandom_range(0, 3)) - 1) : $urandom_range(0, 15);
         addr  = ($urandom_range(0, 3) == 0) ? 32'(DEPTH * 4 - 64 + $urandom_range(0, 127))
                                             : 32'($urandom_range(0, 1023));
         addr  = addr & ~((32'd1 << size) - 32'd1);
         if ($urandom_range(0, 1) == 1) begin
            bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
            write_burst(addr, len, size, burst, 4'($urandom), bad, 1, 0, 32'h0, 4'h0);
         end else begin
            read_burst(addr, len, size, burst, 4'($urandom), -1, 1, 0);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      araddr = 32'h100; arlen = 8'd15; arsize = 3'd2; arburst = 2'd1; arid = 4'hE; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      rready = 1'b1;
      repeat (4) @(negedge clk);
      compared++;
      if (rvalid !== 1'b1) begin mismatched++; $display("FAIL rst_pre: rvalid got %b expected 1", rvalid); end
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0 || rdata !== 32'h0) begin
         mismatched++;
         $display("FAIL rst_mid: got rvalid=%b rlast=%b arready=%b rdata=%h expected 0 0 0 0", rvalid, rlast, arready, rdata);
      end
      rready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (arready !== 1'b1 || rvalid !== 1'b0 || bvalid !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_release: got arready=%b rvalid=%b bvalid=%b expected 1 0 0", arready, rvalid, bvalid);
      end
      read_burst(32'h20, 7, 2, 1, 4'h2, -1, 0, 1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'(i);
      test_reset();
      test_incr_read();
      test_single_write();
      test_wrap_read();
      test_simultaneous();
      test_rready_stall();
      test_decerr();
      test_slverr();
      test_random();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/axi_burst_mem_slave.md
Name: axi_burst_mem_slave

Overview:
AXI4 burst responder that models main memory behind the cache's AXI master port. It is a synthesizable, word-addressed RAM with the full AR/R/AW/W/B channel set. It supports FIXED, INCR and WRAP bursts of up to 256 beats, with one outstanding transaction at a time. It sits at the memory end of the cache simulation, in place of the vendor memory IP.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, beat width; only 32 is supported
ID_WIDTH, 4, AXI ID width
DEPTH_WORDS, 4096, RAM depth in 32-bit words

Ports:
s_aclk  in  1  clock
s_aresetn  in  1  asynchronous active-low reset
s_axi_araddr  in  ADDR_WIDTH  read burst start address
s_axi_arburst  in  2  burst type
s_axi_arid  in  ID_WIDTH  read ID
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  log2 bytes/beat
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  32  read data
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  final read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
s_axi_awaddr  in  ADDR_WIDTH  write burst start address
s_axi_awburst  in  2  burst type
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  log2 bytes/beat
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wlast  in  1  final write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  echoed awid
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready

Behaviour:
- Reset: all ready/valid outputs are 0; rdata, rresp, bresp, rid and bid are 0; rlast is 0; FSM goes to IDLE.
- Reset mid-burst: the burst is aborted and no R or B response is issued. RAM contents are not reset.
- RAM initial contents at time zero: word i = i.
- FSM states: IDLE, RD_BURST, WR_DATA, WR_RESP.
- arready and awready are 1 only in IDLE.
- If arvalid and awvalid are both high in IDLE, the write is accepted first (fixed priority); arready stays 0 that cycle.
- AR handshake: latch address, length, size, burst and ID; go to RD_BURST.
  - First rvalid appears exactly 1 cycle after the handshake.
  - Beats run back-to-back while rready=1.
  - rdata, rresp and rlast are held stable while rvalid=1 and rready=0.
  - rlast=1 when beat count == arlen.
  - Return to IDLE on the last-beat handshake; arready is 1 the following cycle.
- AW handshake: latch the burst; go to WR_DATA.
  - wready=1; each wvalid&wready beat writes the bytes enabled by wstrb.
  - The burst ends when beat count == awlen, regardless of wlast, then go to WR_RESP.
  - WR_RESP: bvalid=1 until bready, then IDLE.
- Next-address rule:
  - FIXED: address held.
  - INCR: address += 1<<size.
  - WRAP: wraps within an aligned (len+1)<<size window.
  - Burst type 2'b11 is treated as INCR with SLVERR.
- Error responses:
  - SLVERR (2'b10) when size>2, burst==2'b11, or wlast mismatches the beat count.
  - DECERR (2'b11) when word index >= DEPTH_WORDS. Reads return 0 and writes are dropped.
  - Response per beat for R; the worst case over the burst for B.
- Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored for data placement.

Optional Feature:
AXI_MEM_RAND_STALL_EN:
- Defined: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - arready, awready and wready are forced 0 when lfsr[0]=1.
  - A new rvalid may only rise when lfsr[0]=0. A raised rvalid is never dropped before its handshake.
- Undefined: no stalls; timing is exactly as in Behaviour.

Decomposition:
- Package axi_mem_pkg contains:
  - burst enum FIXED/INCR/WRAP
  - resp constants OKAY/SLVERR/DECERR
  - FSM state enum
  - function next_beat_addr(addr, len, size, burst)
- One sub-module, axi_mem_bank: the DEPTH_WORDS x 32 array with byte-strobe write, combinational read and identity initialization.

Test Plan:
- INCR read: arlen=3, araddr=0x40 -> rdata 0x10,0x11,0x12,0x13 on consecutive cycles, rlast on beat 4, rresp=0.
- Single write: awaddr=0x8, wdata=0xDEADBEEF, wstrb=4'b0011 -> bresp=0; read of 0x8 returns 0x0000BEEF.
- WRAP read: arlen=3, araddr=0x48 -> 0x12,0x13,0x10,0x11.
- Simultaneous AR(0x0) and AW(0x4, len 0) -> AW handshake first; subsequent read returns the new data at 0x4 only after bvalid.
- Read and write stall behaviour:
  - rready low for 5 cycles during beat 2 of an INCR len=7 burst -> rdata/rlast stable, no beat lost.
  - araddr=DEPTH_WORDS*4 -> rdata=0, rresp=2'b11.
- Reset asserted mid read burst -> rvalid=0 immediately; after release, arready=1 in IDLE and a fresh burst is correct.
